reg_file_ctrl: RTL



---
 rtl/reg_file_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl: byte-stream command decoder driving register file writes/reads with TX read-back
module reg_file_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 1000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData,
  output logic [7:0]            TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY,
  output logic [7:0]            ERR_CNT
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_REQ, RD_WAIT, TX_SEND} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [7:0]            txd_q, txd_d;
  logic                  vld_q, vld_d;
  logic                  wren_q, wren_d;
  logic                  rden_q, rden_d;
  logic [7:0]            err_q, err_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic                  err_inc;
  logic                  timed;
  // next-state decode; strobes are registered from the one-cycle execute states
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    txd_d   = txd_q;
    vld_d   = vld_q;
    tmr_d   = '0;
    err_inc = 1'b0;
    wren_d  = state_q == WR_EXEC;
    rden_d  = state_q == RD_REQ;
    timed   = state_q inside {WR_ADDR, WR_DATA, RD_ADDR};
    case (state_q)
      IDLE: if (RX_D_VLD) begin
        state_d = RX_P_DATA == 8'hAA ? WR_ADDR : RX_P_DATA == 8'hBB ? RD_ADDR : IDLE;
        err_inc = !(RX_P_DATA inside {8'hAA, 8'hBB});
      end
      WR_ADDR: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        wd_d    = DATA_WIDTH'(RX_P_DATA);
        state_d = WR_EXEC;
      end
      WR_EXEC: state_d = IDLE;
      RD_ADDR: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d = RD_REQ;
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: if (!rden_q) begin
        txd_d   = 8'(RdData);
        vld_d   = 1'b1;
        state_d = TX_SEND;
      end
      TX_SEND: if (!TX_BUSY) begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (RX_D_VLD && state_q inside {WR_EXEC, RD_REQ, RD_WAIT, TX_SEND})
      err_inc = 1'b1;
    if (timed && !RX_D_VLD) begin
      state_d = tmr_q == TMR_LAST ? IDLE : state_q;
      err_inc = tmr_q == TMR_LAST;
      tmr_d   = tmr_q == TMR_LAST ? '0 : tmr_q + 1'b1;
    end
    err_d = err_inc && err_q != 8'hFF ? err_q + 8'd1 : err_q;
  end
  // state and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wd_q    <= '0;
      txd_q   <= '0;
      vld_q   <= 1'b0;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      err_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      txd_q   <= txd_d;
      vld_q   <= vld_d;
      wren_q  <= wren_d;
      rden_q  <= rden_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
    end
  end
  assign WrEn      = wren_q;
  assign RdEn      = rden_q;
  assign Address   = addr_q;
  assign WrData    = wd_q;
  assign TX_P_DATA = txd_q;
  assign TX_D_VLD  = vld_q;
  assign ERR_CNT   = err_q;
endmodule
